multicycle_core: RTL and testbench
==================================

MULTICYCLE_CORE -- requirements
Module: multicycle_core

Interface
REQ-001 Parameter DATA_W, 8, datapath/register/data-memory word width, legal 8..16.
REQ-002 Parameter PC_W, 8, program counter and instruction address width, legal 4..16.
REQ-003 Parameter DADDR_W, 7, data-memory address width, legal 1..DATA_W.
REQ-004 clk  in  1  single clock, all state updates on rising edge.
REQ-005 resetN  in  1  reset, asynchronous, active-low.
REQ-006 run  in  1  leave IDLE and begin fetching while high.
REQ-007 imemReq  out  1  instruction fetch request; imemAddr  out  PC_W  fetch address.
REQ-008 imemAck  in  1  fetch complete; imemData  in  16  instruction, valid when imemAck=1.
REQ-009 dmemReq  out  1  data request; dmemWe  out  1  1=write; dmemAddr  out  DADDR_W.
REQ-010 dmemWrData  out  DATA_W; dmemRdData  in  DATA_W, valid when dmemAck=1; dmemAck  in  1.
REQ-011 pc  out  PC_W  current PC; sreg  out  4  {V,N,C,Z} = bits 3..0; halted  out  1.

Function
REQ-012 Encoding: op=[15:12]; rA=[11:9], rB=[8:6], rC=[5:3]; 8 GPRs of DATA_W, none hardwired.
REQ-013 op 0..6: rC <= rA op rB: ADD, SUB, AND, OR, XOR, SHL-by-1 (rA), SHR-by-1 (rA); result truncated to DATA_W.
REQ-014 Flags on ALU ops: Z=result zero; N=result MSB; C=carry (ADD), borrow (SUB), bit shifted out (SHL/SHR), 0 otherwise; V=signed overflow (ADD/SUB), 0 otherwise.
REQ-015 op 8 LDI: GPR[11:9] <= zero-extended [7:0]; op 9 LD: GPR[11:9] <= dmem[GPR[8:6] low DADDR_W bits]; op A ST: dmem[GPR[8:6]] <= GPR[11:9]; flags unchanged.
REQ-016 op B BR: cond [11:9] = always, Z, !Z, C, !C, N, !N, V; if true pc <= [7:0] zero-extended/truncated to PC_W.
REQ-017 op C HALT enters HALTED; ops D,E,F and disabled op 7 are NOPs (no writes, flags unchanged).
REQ-018 States IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED; IDLE->FETCH when run=1.
REQ-019 FETCH: imemReq=1, imemAddr=pc held stable until imemAck sampled 1; then latch instruction, pc <= pc+1 (wraps 2^PC_W-1 -> 0), go DECODE; imemReq low next cycle.
REQ-020 DECODE: read operands; BR updates pc and returns to FETCH; HALT -> HALTED; ALU/LDI/NOP -> EXEC; LD/ST -> MEM.
REQ-021 EXEC: write result and flags, -> FETCH (zero-wait ALU instruction = 3 cycles).
REQ-022 MEM: dmemReq=1, dmemAddr/dmemWe/dmemWrData stable until dmemAck; ST -> FETCH (3 cycles), LD -> WB capturing dmemRdData, WB writes GPR, -> FETCH (4 cycles).
REQ-023 Each memory wait cycle extends latency by exactly one cycle; ack while req low is ignored.
REQ-024 HALTED: halted=1, no requests; run deassert then reassert -> FETCH at current pc with halted=0.
REQ-025 run low in any state other than IDLE/HALTED has no effect; current instruction completes.

Reset
REQ-026 resetN=0 immediately: state IDLE, pc=0, sreg=0, all GPRs=0, imemReq=dmemReq=dmemWe=0, addresses/dmemWrData=0, halted=0.
REQ-027 Reset mid-transaction abandons it; a late ack after release is ignored; no GPR/flag write from the aborted instruction.

Configuration
REQ-028 Macro HEPH_MUL_EN defined: op 7 MUL, GPR[rC] <= product low DATA_W bits, GPR[(rC+1) mod 8] <= high bits, Z=full product zero, C=high half nonzero, N=product MSB, V=0, 4 cycles (EXEC then WB).
REQ-029 HEPH_MUL_EN undefined: op 7 is a NOP, no multiplier logic synthesised.

Verification
REQ-030 Zero-wait memories, LDI r1,0x7F; LDI r2,0x01; ADD r1,r2->r3 -> r3=0x80, sreg V=1,N=1,C=0,Z=0; ADD completes 3 cycles after its fetch request.
REQ-031 SUB r1-r1 then BR Z to 0x10 -> sreg Z=1, next imemAddr=0x10; BR !Z not taken -> imemAddr=pc+1.
REQ-032 ST r3 to addr r2=0x05 with dmemAck delayed 3 cycles -> dmemReq high 4 cycles, stable address 0x05/data 0x80; LD back -> GPR equals 0x80.
REQ-033 pc=2^PC_W-1 fetch NOP -> pc wraps to 0; HALT -> halted=1, no requests until run toggled.
REQ-034 resetN low during LD wait state, ack arriving after release -> all outputs at reset values, GPRs unchanged by ack.
REQ-035 HEPH_MUL_EN defined, 0xFF*0xFF into r6 -> r6=0x01, r7=0xFE, C=1; undefined -> r6/r7/sreg unchanged.

Source files
------------

// File: rtl/multicycle_core_if.sv
// Instruction- and data-memory request/acknowledge bus of the multicycle core.
// The core is the master; memories (or a testbench) are the slave.
interface multicycle_core_if #(
    parameter int PC_W    = 8,
    parameter int DATA_W  = 8,
    parameter int DADDR_W = 7
);
    logic               imemReq;
    logic [PC_W-1:0]    imemAddr;
    logic               imemAck;
    logic [15:0]        imemData;
    logic               dmemReq;
    logic               dmemWe;
    logic [DADDR_W-1:0] dmemAddr;
    logic [DATA_W-1:0]  dmemWrData;
    logic [DATA_W-1:0]  dmemRdData;
    logic               dmemAck;

    modport master (
        output imemReq, imemAddr, dmemReq, dmemWe, dmemAddr, dmemWrData,
        input  imemAck, imemData, dmemRdData, dmemAck
    );
    modport slave (
        input  imemReq, imemAddr, dmemReq, dmemWe, dmemAddr, dmemWrData,
        output imemAck, imemData, dmemRdData, dmemAck
    );
endinterface

// File: rtl/multicycle_core.sv
// Multicycle 16-bit-instruction core: FETCH/DECODE/EXEC/MEM/WB over req/ack memories.
// Optional HEPH_MUL_EN adds op 7 MUL (low half to rC, high half to rC+1 via WB).
module multicycle_core #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int DADDR_W = 7
) (
    input  logic              clk,
    input  logic              resetN,
    input  logic              run,
    multicycle_core_if.master bus,
    output logic [PC_W-1:0]   pc,
    output logic [3:0]        sreg,
    output logic              halted
);
    typedef enum logic [2:0] {IDLE, FETCH, DECODE, EXEC, MEM, WB, HALTED} state_t;

    localparam logic [3:0] OP_ADD  = 4'h0;
    localparam logic [3:0] OP_SUB  = 4'h1;
    localparam logic [3:0] OP_AND  = 4'h2;
    localparam logic [3:0] OP_OR   = 4'h3;
    localparam logic [3:0] OP_XOR  = 4'h4;
    localparam logic [3:0] OP_SHL  = 4'h5;
    localparam logic [3:0] OP_SHR  = 4'h6;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_LD   = 4'h9;
    localparam logic [3:0] OP_ST   = 4'hA;
    localparam logic [3:0] OP_BR   = 4'hB;
    localparam logic [3:0] OP_HALT = 4'hC;
`ifdef HEPH_MUL_EN
    localparam logic [3:0] OP_MUL  = 4'h7;
`endif

    state_t              state;
    logic [15:0]         ir;
    logic [DATA_W-1:0]   gpr [8];
    logic [DATA_W-1:0]   opA, opB, wbData;
    logic [2:0]          wbReg;
    logic                runArmed;
    logic                imemReqQ, dmemReqQ, dmemWeQ;
    logic [PC_W-1:0]     imemAddrQ;
    logic [DADDR_W-1:0]  dmemAddrQ;
    logic [DATA_W-1:0]   dmemWrDataQ;

    assign bus.imemReq    = imemReqQ;
    assign bus.imemAddr   = imemAddrQ;
    assign bus.dmemReq    = dmemReqQ;
    assign bus.dmemWe     = dmemWeQ;
    assign bus.dmemAddr   = dmemAddrQ;
    assign bus.dmemWrData = dmemWrDataQ;

    logic [3:0] op;
    logic [2:0] rA, rB, rC;
    assign op = ir[15:12];
    assign rA = ir[11:9];
    assign rB = ir[8:6];
    assign rC = ir[5:3];

    logic [PC_W-1:0] brTarget;
    logic            brTaken;
    assign brTarget = PC_W'(ir[7:0]);

    // sreg = {V,N,C,Z}
    always_comb begin
        brTaken = 1'b0;
        case (rA)
            3'd0: brTaken = 1'b1;
            3'd1: brTaken = sreg[0];
            3'd2: brTaken = !sreg[0];
            3'd3: brTaken = sreg[1];
            3'd4: brTaken = !sreg[1];
            3'd5: brTaken = sreg[2];
            3'd6: brTaken = !sreg[2];
            default: brTaken = sreg[3];
        endcase
    end

    // One extra bit on the ALU result carries carry/borrow/shifted-out bit.
    logic [DATA_W:0]   aluWide;
    logic [DATA_W-1:0] aluRes;
    logic              aluV;
    logic [3:0]        aluFlags;
    always_comb begin
        aluWide = '0;
        aluV    = 1'b0;
        case (op)
            OP_ADD: aluWide = {1'b0, opA} + {1'b0, opB};
            OP_SUB: aluWide = {1'b0, opA} - {1'b0, opB};
            OP_AND: aluWide = {1'b0, opA & opB};
            OP_OR:  aluWide = {1'b0, opA | opB};
            OP_XOR: aluWide = {1'b0, opA ^ opB};
            OP_SHL: aluWide = {opA, 1'b0};
            OP_SHR: aluWide = {opA[0], 1'b0, opA[DATA_W-1:1]};
            default: aluWide = '0;
        endcase
        aluRes = aluWide[DATA_W-1:0];
        if (op == OP_ADD)
            aluV = (opA[DATA_W-1] == opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
        else if (op == OP_SUB)
            aluV = (opA[DATA_W-1] != opB[DATA_W-1]) && (aluRes[DATA_W-1] != opA[DATA_W-1]);
        aluFlags = {aluV, aluRes[DATA_W-1], aluWide[DATA_W], aluRes == '0};
    end

`ifdef HEPH_MUL_EN
    logic [2*DATA_W-1:0] prod;
    logic [3:0]          mulFlags;
    assign prod     = opA * opB;
    assign mulFlags = {1'b0, prod[2*DATA_W-1], prod[2*DATA_W-1:DATA_W] != '0, prod == '0};
`endif

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            state       <= IDLE;
            pc          <= '0;
            sreg        <= '0;
            halted      <= 1'b0;
            ir          <= '0;
            opA         <= '0;
            opB         <= '0;
            wbReg       <= '0;
            wbData      <= '0;
            runArmed    <= 1'b0;
            imemReqQ    <= 1'b0;
            imemAddrQ   <= '0;
            dmemReqQ    <= 1'b0;
            dmemWeQ     <= 1'b0;
            dmemAddrQ   <= '0;
            dmemWrDataQ <= '0;
            for (int i = 0; i < 8; i++) gpr[i] <= '0;
        end else begin
            case (state)
                IDLE: if (run) begin
                    state     <= FETCH;
                    imemReqQ  <= 1'b1;
                    imemAddrQ <= pc;
                end
                FETCH: if (bus.imemAck) begin
                    ir       <= bus.imemData;
                    pc       <= pc + PC_W'(1);
                    imemReqQ <= 1'b0;
                    state    <= DECODE;
                end
                DECODE: begin
                    opA <= gpr[rA];
                    opB <= gpr[rB];
                    case (op)
                        OP_BR: begin
                            state    <= FETCH;
                            imemReqQ <= 1'b1;
                            if (brTaken) begin
                                pc        <= brTarget;
                                imemAddrQ <= brTarget;
                            end else begin
                                imemAddrQ <= pc;
                            end
                        end
                        OP_HALT: begin
                            state    <= HALTED;
                            halted   <= 1'b1;
                            runArmed <= 1'b0;
                        end
                        OP_LD, OP_ST: begin
                            state     <= MEM;
                            dmemReqQ  <= 1'b1;
                            dmemWeQ   <= (op == OP_ST);
                            dmemAddrQ <= gpr[rB][DADDR_W-1:0];
                            if (op == OP_ST) dmemWrDataQ <= gpr[rA];
                        end
                        default: state <= EXEC;
                    endcase
                end
                EXEC: begin
                    state     <= FETCH;
                    imemReqQ  <= 1'b1;
                    imemAddrQ <= pc;
                    case (op)
                        OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR: begin
                            gpr[rC] <= aluRes;
                            sreg    <= aluFlags;
                        end
                        OP_LDI: gpr[rA] <= DATA_W'(ir[7:0]);
`ifdef HEPH_MUL_EN
                        // High half goes out through WB so the register file keeps one write port.
                        OP_MUL: begin
                            gpr[rC]  <= prod[DATA_W-1:0];
                            sreg     <= mulFlags;
                            wbReg    <= rC + 3'd1;
                            wbData   <= prod[2*DATA_W-1:DATA_W];
                            state    <= WB;
                            imemReqQ <= 1'b0;
                        end
`endif
                        default: ;
                    endcase
                end
                MEM: if (bus.dmemAck) begin
                    dmemReqQ <= 1'b0;
                    dmemWeQ  <= 1'b0;
                    if (dmemWeQ) begin
                        state     <= FETCH;
                        imemReqQ  <= 1'b1;
                        imemAddrQ <= pc;
                    end else begin
                        state  <= WB;
                        wbReg  <= rA;
                        wbData <= bus.dmemRdData;
                    end
                end
                WB: begin
                    gpr[wbReg] <= wbData;
                    state      <= FETCH;
                    imemReqQ   <= 1'b1;
                    imemAddrQ  <= pc;
                end
                HALTED: begin
                    // Resume only on a fresh rising run, not on a run level held through HALT.
                    if (!run) begin
                        runArmed <= 1'b1;
                    end else if (runArmed) begin
                        state     <= FETCH;
                        halted    <= 1'b0;
                        imemReqQ  <= 1'b1;
                        imemAddrQ <= pc;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_multicycle_core.sv
// Scoreboard bench for multicycle_core: directed program, fetch/store expectation queues.
module tb_multicycle_core;
    logic       clk = 1'b0;
    logic       resetN = 1'b1;
    logic       run = 1'b0;
    logic [7:0] pc;
    logic [3:0] sreg;
    logic       halted;

    int checks = 0;
    int errors = 0;

    multicycle_core_if #(.PC_W(8), .DATA_W(8), .DADDR_W(7)) bus ();

    multicycle_core #(.DATA_W(8), .PC_W(8), .DADDR_W(7)) dut (
        .clk(clk), .resetN(resetN), .run(run), .bus(bus),
        .pc(pc), .sreg(sreg), .halted(halted)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [6:0] addr;
        logic [7:0] data;
        logic [3:0] flags;
    } st_t;

    st_t        stQ[$];
    logic [7:0] fQ[$];

    logic [15:0] imem [256];
    logic [7:0]  dmem [128];
    int          dWait = 3;
    int          dCnt = 0;
    bit          spur = 1'b0;

    function automatic logic [15:0] encR(input int op, input int a, input int b, input int c);
        logic [15:0] w;
        w = 16'((op << 12) | (a << 9) | (b << 6) | (c << 3));
        return w;
    endfunction

    function automatic logic [15:0] encI(input int op, input int a, input int imm);
        logic [15:0] w;
        w = 16'((op << 12) | (a << 9) | (imm & 8'hFF));
        return w;
    endfunction

    // Memory models respond 1 time unit after the edge, so ack can be zero-wait.
    always @(posedge clk) begin
        #1;
        bus.imemAck  = bus.imemReq || spur;
        bus.imemData = imem[bus.imemAddr];
    end

    always @(posedge clk) begin
        #1;
        bus.dmemAck = 1'b0;
        if (spur) begin
            bus.dmemAck = 1'b1;
            dCnt = 0;
        end else if (bus.dmemReq) begin
            if (dCnt == dWait) begin
                bus.dmemAck = 1'b1;
                dCnt = 0;
                if (bus.dmemWe) dmem[bus.dmemAddr] = bus.dmemWrData;
                else bus.dmemRdData = dmem[bus.dmemAddr];
            end else begin
                dCnt++;
            end
        end else begin
            dCnt = 0;
        end
    end

    // Monitor: pops expected fetch addresses and stores; checks dmem hold/latency.
    bit         dPrev = 1'b0;
    int         dLen = 0;
    bit         dStable = 1'b1;
    logic [6:0] dA0;
    logic [7:0] dD0;
    logic [7:0] fExp;
    st_t        sExp;
    always @(negedge clk) begin
        if (!resetN) begin
            dPrev = 1'b0;
        end else begin
            if (bus.imemReq && bus.imemAck) begin
                checks++;
                if (fQ.size() == 0) begin
                    errors++;
                    $display("FAIL fetch unexpected addr=%h", bus.imemAddr);
                end else begin
                    fExp = fQ.pop_front();
                    if (bus.imemAddr !== fExp) begin
                        errors++;
                        $display("FAIL fetch addr got=%h exp=%h", bus.imemAddr, fExp);
                    end
                end
            end
            if (bus.dmemReq) begin
                if (!dPrev) begin
                    dLen = 1; dA0 = bus.dmemAddr; dD0 = bus.dmemWrData; dStable = 1'b1;
                end else begin
                    dLen++;
                    if (bus.dmemAddr !== dA0 || bus.dmemWrData !== dD0) dStable = 1'b0;
                end
                if (bus.dmemAck) begin
                    checks++;
                    if (dLen != dWait + 1 || !dStable) begin
                        errors++;
                        $display("FAIL dmem hold len=%0d exp=%0d stable=%0d", dLen, dWait + 1, dStable);
                    end
                    if (bus.dmemWe) begin
                        checks++;
                        if (stQ.size() == 0) begin
                            errors++;
                            $display("FAIL store unexpected addr=%h data=%h", bus.dmemAddr, bus.dmemWrData);
                        end else begin
                            sExp = stQ.pop_front();
                            if (bus.dmemAddr !== sExp.addr || bus.dmemWrData !== sExp.data || sreg !== sExp.flags) begin
                                errors++;
                                $display("FAIL store got a=%h d=%h sreg=%h exp a=%h d=%h sreg=%h",
                                         bus.dmemAddr, bus.dmemWrData, sreg, sExp.addr, sExp.data, sExp.flags);
                            end
                        end
                    end
                end
            end
            dPrev = bus.dmemReq && !bus.dmemAck;
        end
    end

    // kind 0: fetch of address a; kind 1: halted high; kind 2: dmemReq high
    task automatic waitFor(input int kind, input logic [7:0] a, input int bound, input string name);
        bit hit;
        hit = 1'b0;
        for (int i = 0; i < bound && !hit; i++) begin
            @(negedge clk);
            case (kind)
                0: hit = bus.imemReq && bus.imemAddr == a;
                1: hit = halted;
                default: hit = bus.dmemReq;
            endcase
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL timeout %s got=never required=%0d", name, kind);
        end
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic push(input logic [6:0] a, input logic [7:0] d, input logic [3:0] f);
        st_t s;
        s.addr = a; s.data = d; s.flags = f;
        stQ.push_back(s);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=running required=finished");
        $fatal(1);
    end

    initial begin
        bit quiet;
        bus.imemAck = 1'b0; bus.imemData = '0; bus.dmemAck = 1'b0; bus.dmemRdData = '0;
        for (int i = 0; i < 256; i++) imem[i] = 16'hD000;
        for (int i = 0; i < 128; i++) dmem[i] = 8'h00;

        // Program and hand-computed store expectations {addr, data, sreg}
        imem[8'h00] = encI(8, 1, 8'h7F);
        imem[8'h01] = encI(8, 2, 8'h01);
        imem[8'h02] = encR(0, 1, 2, 3);             // ADD r3=0x80
        imem[8'h03] = encR(10, 3, 2, 0);  push(7'h01, 8'h80, 4'hC);
        imem[8'h04] = encR(1, 1, 1, 4);             // SUB -> Z
        imem[8'h05] = encI(11, 1, 8'h10);           // BR Z taken
        imem[8'h06] = 16'hC000;
        imem[8'h10] = encI(11, 2, 8'h20);           // BR !Z not taken
        imem[8'h11] = encI(8, 2, 8'h05);
        imem[8'h12] = encR(10, 3, 2, 0);  push(7'h05, 8'h80, 4'h1);
        imem[8'h13] = encR(9, 5, 2, 0);             // LD r5
        imem[8'h14] = encI(8, 6, 8'h06);
        imem[8'h15] = encR(10, 5, 6, 0);  push(7'h06, 8'h80, 4'h1);
        imem[8'h16] = encI(8, 1, 8'hC3);
        imem[8'h17] = encI(8, 2, 8'h0F);
        imem[8'h18] = encR(2, 1, 2, 4);
        imem[8'h19] = encR(10, 4, 6, 0);  push(7'h06, 8'h03, 4'h0);
        imem[8'h1A] = encR(3, 1, 2, 4);
        imem[8'h1B] = encR(10, 4, 6, 0);  push(7'h06, 8'hCF, 4'h4);
        imem[8'h1C] = encR(4, 1, 2, 4);
        imem[8'h1D] = encR(10, 4, 6, 0);  push(7'h06, 8'hCC, 4'h4);
        imem[8'h1E] = encR(5, 1, 0, 4);
        imem[8'h1F] = encR(10, 4, 6, 0);  push(7'h06, 8'h86, 4'h6);
        imem[8'h20] = encR(6, 1, 0, 4);
        imem[8'h21] = encR(10, 4, 6, 0);  push(7'h06, 8'h61, 4'h2);
        imem[8'h22] = encI(8, 1, 8'h80);
        imem[8'h23] = encR(1, 1, 2, 4);             // 0x80-0x0F: V
        imem[8'h24] = encR(10, 4, 6, 0);  push(7'h06, 8'h71, 4'h8);
        imem[8'h25] = encR(1, 2, 1, 4);             // 0x0F-0x80: V,N,borrow
        imem[8'h26] = encR(10, 4, 6, 0);  push(7'h06, 8'h8F, 4'hE);
        imem[8'h27] = encR(0, 1, 1, 4);             // 0x80+0x80: V,C,Z
        imem[8'h28] = encR(10, 4, 6, 0);  push(7'h06, 8'h00, 4'hB);
        imem[8'h29] = encI(11, 3, 8'h30);           // BR C taken
        imem[8'h2A] = 16'hC000;
        imem[8'h30] = encI(8, 1, 8'hFF);
        imem[8'h31] = encR(7, 1, 1, 6);             // MUL / NOP
        imem[8'h32] = encR(10, 6, 2, 0);
        imem[8'h33] = encR(10, 7, 2, 0);
        imem[8'h34] = 16'hEFFF;
        imem[8'h35] = 16'hFFFF;
        imem[8'h36] = encR(10, 7, 2, 0);
        imem[8'h37] = encI(11, 0, 8'hFE);           // BR always
`ifdef HEPH_MUL_EN
        push(7'h0F, 8'h01, 4'h6); push(7'h0F, 8'hFE, 4'h6); push(7'h0F, 8'hFE, 4'h6);
`else
        push(7'h0F, 8'h06, 4'hB); push(7'h0F, 8'h00, 4'hB); push(7'h0F, 8'h00, 4'hB);
`endif
        for (int a = 8'h00; a <= 8'h05; a++) fQ.push_back(8'(a));
        for (int a = 8'h10; a <= 8'h29; a++) fQ.push_back(8'(a));
        for (int a = 8'h30; a <= 8'h37; a++) fQ.push_back(8'(a));
        fQ.push_back(8'hFE); fQ.push_back(8'hFF); fQ.push_back(8'h00);

        #2 resetN = 1'b0;
        #4;
        check("reset outputs", {pc, sreg, halted, bus.imemReq, bus.dmemReq, bus.dmemWe},
              {8'h00, 4'h0, 1'b0, 1'b0, 1'b0, 1'b0});
        repeat (2) @(negedge clk);
        resetN = 1'b1;
        repeat (3) @(negedge clk);
        check("idle no fetch", {bus.imemReq, bus.imemAddr, pc}, {1'b0, 8'h00, 8'h00});

        run = 1'b1;
        waitFor(0, 8'h00, 10, "first fetch");
        run = 1'b0;                                 // no effect while running
        waitFor(0, 8'h02, 50, "fetch ADD");
        repeat (2) @(negedge clk);
        check("sreg before ADD write", sreg, 4'h0);
        @(negedge clk);
        check("sreg ADD 3 cycles", sreg, 4'hC);

        waitFor(0, 8'h30, 1000, "fetch 0x30");
        run = 1'b1;
        waitFor(0, 8'hFF, 200, "fetch 0xFF");
        imem[8'h00] = 16'hC000;
        @(negedge clk);
        check("pc wrap", pc, 8'h00);
        waitFor(1, 8'h00, 50, "halt");
        check("halt pc", pc, 8'h01);

        imem[8'h01] = 16'hC000;
        fQ.push_back(8'h01);
        quiet = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.imemReq || bus.dmemReq || !halted) quiet = 1'b0;
        end
        check("halted quiet with run held", quiet, 1'b1);
        run = 1'b0;
        repeat (2) @(negedge clk);
        run = 1'b1;
        waitFor(0, 8'h01, 10, "resume fetch");
        check("halted cleared", halted, 1'b0);
        waitFor(1, 8'h00, 20, "halt again");
        check("pc after rehalt", pc, 8'h02);

        // Abort a LD in its wait state; the late ack must not load r1.
        @(negedge clk);
        run = 1'b0;
        resetN = 1'b0;
        @(negedge clk);
        resetN = 1'b1;
        imem[8'h00] = encR(9, 1, 0, 0);
        dmem[0] = 8'h55;
        dWait = 20;
        fQ.push_back(8'h00);
        run = 1'b1;
        waitFor(2, 8'h00, 20, "LD request");
        repeat (2) @(negedge clk);
        resetN = 1'b0;
        run = 1'b0;
        #1;
        check("mid-LD reset outputs",
              {pc, sreg, halted, bus.imemReq, bus.imemAddr, bus.dmemReq, bus.dmemWe, bus.dmemAddr, bus.dmemWrData},
              {8'h00, 4'h0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 7'h00, 8'h00});
        @(negedge clk);
        resetN = 1'b1;
        spur = 1'b1;
        repeat (3) @(negedge clk);
        check("late ack ignored", {bus.imemReq, bus.dmemReq, pc, halted}, {1'b0, 1'b0, 8'h00, 1'b0});
        spur = 1'b0;
        dWait = 0;
        imem[8'h00] = encR(10, 1, 0, 0);            // ST r1,[r0]
        imem[8'h01] = 16'hC000;
        push(7'h00, 8'h00, 4'h0);
        fQ.push_back(8'h00); fQ.push_back(8'h01);
        @(negedge clk);
        run = 1'b1;
        waitFor(1, 8'h00, 50, "final halt");
        repeat (2) @(negedge clk);
        check("queues drained", {16'(fQ.size()), 16'(stQ.size())}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
